// File: rtl/mem_load_unit_pkg.sv
// Shared definitions for the load unit: load op codes, FSM state encoding,
// default address map and the access-size helper.
package mem_load_unit_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LBU = 3'b001;
  localparam logic [2:0] OP_LB  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b011;
  localparam logic [2:0] OP_LH  = 3'b100;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD0 = 3'd1;
  localparam logic [2:0] ST_DAT0 = 3'd2;
  localparam logic [2:0] ST_CMD1 = 3'd3;
  localparam logic [2:0] ST_DAT1 = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

  localparam logic [31:0] DEF_DM_TOP    = 32'h0000_2fff;
  localparam logic [31:0] DEF_TMR0_BASE = 32'h0000_7f00;
  localparam logic [31:0] DEF_TMR1_BASE = 32'h0000_7f10;
  localparam logic [31:0] DEF_INT_BASE  = 32'h0000_7f20;
  localparam logic [31:0] TMR_SPAN      = 32'd12;
  localparam logic [31:0] INT_SPAN      = 32'd4;

  // Access size in bytes; 0 marks an illegal op code.
  function automatic logic [2:0] op_size(input logic [2:0] op);
    case (op)
      OP_LW:         op_size = 3'd4;
      OP_LBU, OP_LB: op_size = 3'd1;
      OP_LHU, OP_LH: op_size = 3'd2;
      default:       op_size = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_unit_load_extend.sv
// Little-endian merge of two bus words plus zero/sign extension of the
// selected byte, half or word.
module load_extend
  import mem_load_unit_pkg::*;
(
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  input  logic [1:0]  offset,
  input  logic [2:0]  op,
  output logic [31:0] result
);

  logic [63:0] merged;

  always_comb begin
    merged = {word1, word0} >> {offset, 3'b000};
    case (op)
      OP_LW:   result = merged[31:0];
      OP_LBU:  result = {24'h0, merged[7:0]};
      OP_LB:   result = {{24{merged[7]}}, merged[7:0]};
      OP_LHU:  result = {16'h0, merged[15:0]};
      OP_LH:   result = {{16{merged[15]}}, merged[15:0]};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// Load unit: decodes AdEL at acceptance, fetches one or two bus words and
// returns the extended result. LOAD_UNALIGNED_EN enables misaligned DM loads.
//
// state   | meaning
// IDLE    | ready for a request
// CMD0    | issuing read of first word
// DAT0    | waiting for first word
// CMD1    | issuing read of next word (word-crossing access)
// DAT1    | waiting for next word
// RESP    | holding result until resp_ready
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] DM_TOP    = DEF_DM_TOP,
  parameter logic [31:0] TMR0_BASE = DEF_TMR0_BASE,
  parameter logic [31:0] TMR1_BASE = DEF_TMR1_BASE,
  parameter logic [31:0] INT_BASE  = DEF_INT_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_op,
  input  logic              req_ov,
  output logic              bus_cmd_valid,
  input  logic              bus_cmd_ready,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_adel
);

  localparam int AW1 = ADDR_W + 1;

  logic [2:0]     state;
  logic [1:0]     offset_q;
  logic [2:0]     op_q;
  logic           cross_q;
  logic [31:0]    word0;

  logic [2:0]     size;
  logic [AW1-1:0] a_ext;
  logic           in_dm, in_tmr, in_int, op_bad, misaligned, crossing, adel;
`ifdef LOAD_UNALIGNED_EN
  logic [AW1-1:0] last_byte;
`endif

  // Address widened by one bit so window and end-of-DM compares cannot wrap.
  always_comb begin
    size       = op_size(req_op);
    a_ext      = {1'b0, req_addr};
    in_dm      = a_ext <= AW1'(DM_TOP);
    in_tmr     = (a_ext >= AW1'(TMR0_BASE) && a_ext < AW1'(TMR0_BASE) + AW1'(TMR_SPAN)) ||
                 (a_ext >= AW1'(TMR1_BASE) && a_ext < AW1'(TMR1_BASE) + AW1'(TMR_SPAN));
    in_int     = a_ext >= AW1'(INT_BASE) && a_ext < AW1'(INT_BASE) + AW1'(INT_SPAN);
    op_bad     = size == 3'd0;
    misaligned = (req_op == OP_LW && req_addr[1:0] != 2'b00) ||
                 ((req_op == OP_LH || req_op == OP_LHU) && req_addr[0]);
    crossing   = ({1'b0, req_addr[1:0]} + size) > 3'd4;
    adel       = req_ov || op_bad || !(in_dm || in_tmr || in_int) ||
                 (in_tmr && req_op != OP_LW);
`ifdef LOAD_UNALIGNED_EN
    last_byte  = a_ext + AW1'(size) - AW1'(1);
    if (misaligned && (!in_dm || last_byte > AW1'(DM_TOP))) adel = 1'b1;
`else
    if (misaligned) adel = 1'b1;
`endif
  end

  logic [31:0] ext_word0, ext_result;

  // In DAT0 the first word is still on the bus; in DAT1 it has been captured.
  assign ext_word0 = (state == ST_DAT0) ? bus_rdata : word0;

  load_extend u_load_extend (
    .word0  (ext_word0),
    .word1  (bus_rdata),
    .offset (offset_q),
    .op     (op_q),
    .result (ext_result)
  );

  assign req_ready     = state == ST_IDLE;
  assign bus_cmd_valid = (state == ST_CMD0) || (state == ST_CMD1);
  assign resp_valid    = state == ST_RESP;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      offset_q  <= 2'b00;
      op_q      <= OP_LW;
      cross_q   <= 1'b0;
      word0     <= 32'h0;
      bus_addr  <= '0;
      resp_data <= 32'h0;
      resp_adel <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            offset_q <= req_addr[1:0];
            op_q     <= req_op;
            cross_q  <= crossing;
            if (adel) begin
              state     <= ST_RESP;
              resp_data <= 32'h0;
              resp_adel <= 1'b1;
            end else begin
              state    <= ST_CMD0;
              bus_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        ST_CMD0: if (bus_cmd_ready) state <= ST_DAT0;
        ST_DAT0: begin
          if (bus_rvalid) begin
            word0 <= bus_rdata;
            if (cross_q) begin
              state    <= ST_CMD1;
              bus_addr <= bus_addr + ADDR_W'(4);
            end else begin
              state     <= ST_RESP;
              resp_data <= ext_result;
              resp_adel <= 1'b0;
            end
          end
        end
        ST_CMD1: if (bus_cmd_ready) state <= ST_DAT1;
        ST_DAT1: begin
          if (bus_rvalid) begin
            state     <= ST_RESP;
            resp_data <= ext_result;
            resp_adel <= 1'b0;
          end
        end
        ST_RESP: if (resp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_load_unit.md
MEM_LOAD_UNIT -- requirements
Module: mem_load_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: request and bus address width.
REQ-002 SHALL have parameter DM_TOP, default 32'h0000_2fff: last byte address of data memory; DM spans 0..DM_TOP.
REQ-003 SHALL have parameters TMR0_BASE 32'h7f00, TMR1_BASE 32'h7f10 (12-byte windows) and INT_BASE 32'h7f20 (4-byte window).
REQ-004 SHALL have ports: clk in 1, the single clock; reset in 1, synchronous, active-high.
REQ-005 SHALL have ports: req_valid in 1, load request; req_ready out 1, request accepted; req_addr in ADDR_W, byte address; req_op in 3, load op; req_ov in 1, address-calculation overflow.
REQ-006 SHALL have ports: bus_cmd_valid out 1; bus_cmd_ready in 1; bus_addr out ADDR_W, always word-aligned; bus_rvalid in 1; bus_rdata in 32.
REQ-007 SHALL have ports: resp_valid out 1; resp_ready in 1; resp_data out 32, extended load result; resp_adel out 1, AdEL exception.

Function
REQ-008 req_op encoding SHALL be 000 LW, 001 LBU, 010 LB, 011 LHU, 100 LH; other codes SHALL raise AdEL.
REQ-009 SHALL use FSM states IDLE, CMD0, DAT0, CMD1, DAT1, RESP; req_ready SHALL be 1 only in IDLE.
REQ-010 A request SHALL be accepted when req_valid && req_ready; addr, op and ov are latched on that edge.
REQ-011 AdEL SHALL be flagged at acceptance for: req_ov=1; address outside DM and all three peripheral windows; sub-word op (001..100) to a timer window; misalignment not permitted per REQ-019/020.
REQ-012 On AdEL, IDLE SHALL go directly to RESP with resp_data=0 and resp_adel=1; no bus command is issued.
REQ-013 Otherwise IDLE SHALL go to CMD0, driving bus_cmd_valid=1 and bus_addr={addr[ADDR_W-1:2],2'b00} until bus_cmd_ready, then go to DAT0.
REQ-014 DAT0 SHALL wait for bus_rvalid, capture bus_rdata as word0, then go to CMD1 if the access crosses a word boundary, else to RESP.
REQ-015 CMD1/DAT1 SHALL fetch word0 address + 4 as word1, then go to RESP.
REQ-016 Result SHALL be the 64-bit {word1,word0} shifted right by 8*addr[1:0] (little-endian), low byte/half zero- or sign-extended per op; LW takes all 32 bits.
REQ-017 RESP SHALL hold resp_valid=1 with stable data and exception flag until resp_ready, then go to IDLE; the next request is accepted no earlier than the following cycle.
REQ-018 bus_rvalid outside DAT0/DAT1 and bus_cmd_ready outside CMD0/CMD1 SHALL be ignored; exactly one outstanding bus read.

Reset
REQ-021 reset SHALL force IDLE from any state, including mid-transaction, discarding captured words.
REQ-022 Reset values: req_ready=1, bus_cmd_valid=0, bus_addr=0, resp_valid=0, resp_data=0, resp_adel=0.

Configuration
REQ-019 Without LOAD_UNALIGNED_EN, LW with addr[1:0]!=0 and LH/LHU with addr[0]=1 SHALL raise AdEL; no access ever crosses a word boundary.
REQ-020 With LOAD_UNALIGNED_EN defined, misaligned LW/LH/LHU SHALL be legal in DM only; word-crossing accesses use two beats; a crossing access whose last byte exceeds DM_TOP, or any misaligned peripheral access, SHALL raise AdEL.

Structure
REQ-023 A shared package SHALL hold the op-code constants, FSM state encoding and default address-map constants.
REQ-024 Extension/merge logic SHALL be a combinational sub-module load_extend (inputs word0, word1, byte offset, op; output 32-bit result).

Verification
REQ-025 LB addr 0x0003, rdata 0x80FF_1234 -> one beat, resp_data 0xFFFF_FF80, resp_adel=0.
REQ-026 LHU addr 0x7f04 -> AdEL, no bus_cmd_valid, resp_data 0.
REQ-027 req_ov=1, LW addr 0x0100 -> resp_adel=1 after exactly one cycle in RESP path, no bus activity.
REQ-028 LOAD_UNALIGNED_EN: LW addr 0x0006, word0 0x4433_2211, word1 0x8877_6655 -> bus reads 0x0004 then 0x0008, resp_data 0x6655_4433; without macro -> AdEL.
REQ-029 reset asserted in DAT1 with bus_cmd_ready/rvalid delayed 3 cycles -> IDLE next cycle, resp_valid=0, late rvalid ignored.
REQ-030 resp_ready held low 5 cycles -> resp_valid and resp_data stable, req_ready=0 throughout.
